// File: rtl/logic_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_pkg
//  Description : Shared definitions for the logic gate unit: op encodings,
//                statistics counter width and the per-bit gate function.
//  Revision    : 1.0 - initial release
// ============================================================================
package logic_gate_pkg;

    // Function-select encodings carried on op / op_out
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    // Width of the optional accepted-beat counter
    localparam int STATS_W = 16;

    // One result bit from one bit of each operand. The unit applies this
    // across every bit position, so the WIDTH-bit result is bitwise by
    // construction and the package stays independent of WIDTH.
    function automatic logic lgu_gate_bit(input logic a, input logic b,
                                          input logic [2:0] op);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOT:  r = ~a;
            default: r = a;          // OP_BUF
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lgu_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : lgu_fifo
//  Description : Generic synchronous FIFO, DEPTH x DATA_W, with occupancy
//                count and full/empty flags. Storage is cleared on reset so
//                the head read port shows zero until the first write.
//  Revision    : 1.0 - initial release
// ============================================================================
module lgu_fifo #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign full    = (r_count == c_depth);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];

    // Storage write at the tail; entries cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers (natural power-of-two wrap) and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_gate_unit.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_unit
//  Description : Registered bitwise logic unit. Computes one of eight gate
//                functions on WIDTH-bit operands plus AND/OR/XOR reductions,
//                and queues results behind a valid/ready handshake.
//                Optional macro LGU_STATS_EN adds a saturating 16-bit
//                accepted-beat counter on port accept_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor,
    output logic [2:0]       op_out
`ifdef LGU_STATS_EN
    ,
    output logic [STATS_W-1:0] accept_cnt
`endif
);

    localparam int             c_entry_w = WIDTH + 6;
    localparam int             c_cnt_w   = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]     w_res;
    logic [c_entry_w-1:0] w_wr_entry;
    logic [c_entry_w-1:0] w_rd_entry;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    // Gate function applied at every bit position
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_res[gi] = lgu_gate_bit(a[gi], b[gi], op);
        end
    endgenerate

    // Handshake flags come from the registered count only, so in_ready has
    // no combinational path from out_ready.
    assign in_ready  = (w_count != c_depth);
    assign out_valid = (w_count != '0);
    assign w_push    = in_valid && !w_full;
    assign w_pop     = out_ready && !w_empty;

    // Entry layout: {op, red_xor, red_or, red_and, y}
    assign w_wr_entry = {op, ^w_res, |w_res, &w_res, w_res};

    lgu_fifo #(
        .DATA_W (c_entry_w),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (w_wr_entry),
        .rd_en   (w_pop),
        .rd_data (w_rd_entry),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign y       = w_rd_entry[WIDTH-1:0];
    assign red_and = w_rd_entry[WIDTH];
    assign red_or  = w_rd_entry[WIDTH+1];
    assign red_xor = w_rd_entry[WIDTH+2];
    assign op_out  = w_rd_entry[WIDTH+5:WIDTH+3];

`ifdef LGU_STATS_EN
    logic [STATS_W-1:0] r_accept_cnt;

    // Saturating count of accepted beats, stepping on the push edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_accept_cnt <= '0;
        end else if (w_push && (r_accept_cnt != '1)) begin
            r_accept_cnt <= r_accept_cnt + 1'b1;
        end
    end

    assign accept_cnt = r_accept_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_gate_unit
//  Description : Directed self-checking bench for logic_gate_unit
//                (WIDTH=4, DEPTH=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_gate_unit;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             red_and;
    logic             red_or;
    logic             red_xor;
    logic [2:0]       op_out;
`ifdef LGU_STATS_EN
    logic [15:0]      accept_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] exp_y   [8];
    logic       exp_par [8];

    logic_gate_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .red_and   (red_and),
        .red_or    (red_or),
        .red_xor   (red_xor),
        .op_out    (op_out)
`ifdef LGU_STATS_EN
        ,
        .accept_cnt (accept_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_y[0] = 4'b1000; exp_par[0] = 1'b1;
        exp_y[1] = 4'b1110; exp_par[1] = 1'b1;
        exp_y[2] = 4'b0111; exp_par[2] = 1'b1;
        exp_y[3] = 4'b0001; exp_par[3] = 1'b1;
        exp_y[4] = 4'b0110; exp_par[4] = 1'b0;
        exp_y[5] = 4'b1001; exp_par[5] = 1'b0;
        exp_y[6] = 4'b0011; exp_par[6] = 1'b0;
        exp_y[7] = 4'b1100; exp_par[7] = 1'b0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_y",         32'(y),         32'd0);
        chk("rst_red_or",    32'(red_or),    32'd0);
        chk("rst_op_out",    32'(op_out),    32'd0);
`ifdef LGU_STATS_EN
        chk("rst_accept_cnt", 32'(accept_cnt), 32'd0);
`endif

        // All eight ops back to back, a=1100 b=1010
        a = 4'b1100; b = 4'b1010; out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            op = 3'(k);
            step();
            chk($sformatf("op%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("op%0d_y", k),     32'(y),         32'(exp_y[k]));
            chk($sformatf("op%0d_xor", k),   32'(red_xor),   32'(exp_par[k]));
            chk($sformatf("op%0d_op", k),    32'(op_out),    32'(k));
        end
        in_valid = 1'b0;
        step();
        chk("drain1_valid", 32'(out_valid), 32'd0);

        // Reductions with BUF A
        op = 3'd7; in_valid = 1'b1;
        a = 4'hF; step();
        chk("redF_y", 32'(y), 32'hF);
        chk("redF_and_or_xor", 32'({red_and, red_or, red_xor}), 32'b110);
        a = 4'h0; step();
        chk("red0_and_or_xor", 32'({red_and, red_or, red_xor}), 32'b000);
        a = 4'h1; step();
        chk("red1_and_or_xor", 32'({red_and, red_or, red_xor}), 32'b011);
        in_valid = 1'b0; step();
        chk("drain2_valid", 32'(out_valid), 32'd0);

        // Backpressure: three beats into a two-entry queue
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd7;
        a = 4'h1; chk("bp_rdy1", 32'(in_ready), 32'd1); step();
        a = 4'h2; chk("bp_rdy2", 32'(in_ready), 32'd1); step();
        a = 4'h3; chk("bp_rdy3", 32'(in_ready), 32'd0); step();
        chk("bp_held_rdy", 32'(in_ready), 32'd0);
        chk("bp_held_y",   32'(y),        32'h1);
        chk("bp_held_vld", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_pop1_y",   32'(y),        32'h2);
        chk("bp_pop1_rdy", 32'(in_ready), 32'd1);
        step();
        chk("bp_pop2_y",   32'(y),        32'h3);
        in_valid = 1'b0;
        step();
        chk("bp_drain_vld", 32'(out_valid), 32'd0);

        // Streaming at count=1: push and pop every cycle
        out_ready = 1'b0; in_valid = 1'b1; a = 4'h0;
        step();
        chk("str_head0", 32'(y), 32'h0);
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            a = 4'(i);
            step();
            chk($sformatf("str_y%0d", i),   32'(y),         32'(i));
            chk($sformatf("str_v%0d", i),   32'(out_valid), 32'd1);
            chk($sformatf("str_rdy%0d", i), 32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("str_drain_vld", 32'(out_valid), 32'd0);

        // Reset with two entries queued discards them
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd7;
        a = 4'h5; step();
        a = 4'h6; step();
        chk("mr_full_rdy", 32'(in_ready), 32'd0);
        in_valid = 1'b0; rst = 1'b1; a = 4'h9;
        step();
        chk("mr_vld",    32'(out_valid), 32'd0);
        chk("mr_rdy",    32'(in_ready),  32'd1);
        chk("mr_y",      32'(y),         32'd0);
        chk("mr_op_out", 32'(op_out),    32'd0);
        rst = 1'b0; out_ready = 1'b1;
        step();
        chk("mr_stale_vld", 32'(out_valid), 32'd0);
        chk("mr_stale_y",   32'(y),         32'd0);

`ifdef LGU_STATS_EN
        // Accept counter and saturation
        chk("st_zero", 32'(accept_cnt), 32'd0);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0; step();
        chk("st_five", 32'(accept_cnt), 32'd5);
        in_valid = 1'b1;
        for (int i = 0; i < 65529; i++) step();
        in_valid = 1'b0; step();
        chk("st_fffe", 32'(accept_cnt), 32'hFFFE);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0; step();
        chk("st_sat", 32'(accept_cnt), 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
